// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Multiply completes after MUL_CYCLES cycles. Divide is restoring radix-2,
// producing one quotient bit per cycle. Divide by zero finishes in one cycle.
// Optional feature: define MULDIV_FLUSH_EN to add a flush port that aborts an
// in-flight op.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
`ifdef MULDIV_FLUSH_EN
  input  logic             flush,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  // The counter must hold WIDTH-1 for divide and MUL_CYCLES-2 (at most 6) for multiply.
  localparam int CW = $clog2(WIDTH > 8 ? WIDTH : 8) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               mul_signed_reg;
  logic [WIDTH-1:0]   quo_reg, rem_reg, dvs_reg;
  logic               neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               dz_reg;

  logic               flush_int;
  logic               accept, dz_start, mul_last, div_last;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic               mul_signed;
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;
  logic [WIDTH:0]     trial;
  logic               qbit;
  logic [WIDTH-1:0]   quo_step, rem_step;
  logic               res_wr;
  logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MULDIV_FLUSH_EN
  assign flush_int = flush;
`else
  assign flush_int = 1'b0;
`endif

  // Issue decode, multiplier, divider step and result selection.
  always_comb begin
    accept   = start && !flush_int && (state_reg == S_IDLE || state_reg == S_DONE);
    dz_start = accept && op[1] && (b == '0);
    mul_last = (state_reg == S_MUL) && (cnt_reg == CW'(MUL_CYCLES - 2));
    div_last = (state_reg == S_DIV) && (cnt_reg == CW'(WIDTH - 1));

    // A one-cycle multiply has to use the live operands, since it finishes on the accepting edge.
    mul_a      = (MUL_CYCLES == 1) ? a : a_reg;
    mul_b      = (MUL_CYCLES == 1) ? b : b_reg;
    mul_signed = (MUL_CYCLES == 1) ? ~op[0] : mul_signed_reg;
    mul_a_ext  = {{WIDTH{mul_signed & mul_a[WIDTH-1]}}, mul_a};
    mul_b_ext  = {{WIDTH{mul_signed & mul_b[WIDTH-1]}}, mul_b};
    product    = mul_a_ext * mul_b_ext;

    // Restoring step: shift in the next dividend bit and try to subtract the divisor.
    trial    = {rem_reg, quo_reg[WIDTH-1]} - {1'b0, dvs_reg};
    qbit     = ~trial[WIDTH];
    rem_step = qbit ? trial[WIDTH-1:0] : {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
    quo_step = {quo_reg[WIDTH-2:0], qbit};

    res_wr = 1'b0;
    res_hi = '0;
    res_lo = '0;
    if (dz_start) begin
      res_wr = 1'b1;
      res_hi = a;
      res_lo = '1;
    end else if ((accept && !op[1] && MUL_CYCLES == 1) || (mul_last && !flush_int)) begin
      res_wr = 1'b1;
      res_hi = product[2*WIDTH-1:WIDTH];
      res_lo = product[WIDTH-1:0];
    end else if (div_last && !flush_int) begin
      // The last quotient bit and the sign fix-up are applied on the same edge.
      res_wr = 1'b1;
      res_hi = neg_r_reg ? -rem_step : rem_step;
      res_lo = neg_q_reg ? -quo_step : quo_step;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        done = (state_reg == S_DONE);
        if (accept) begin
          if (op[1])                state_next = dz_start ? S_DONE : S_DIV;
          else if (MUL_CYCLES == 1) state_next = S_DONE;
          else                      state_next = S_MUL;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (flush_int)     state_next = S_IDLE;
        else if (mul_last) state_next = S_DONE;
      end
      S_DIV: begin
        busy = 1'b1;
        if (flush_int)     state_next = S_IDLE;
        else if (div_last) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand latching, iteration counter, divider registers and HI/LO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg        <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      mul_signed_reg <= 1'b0;
      quo_reg        <= '0;
      rem_reg        <= '0;
      dvs_reg        <= '0;
      neg_q_reg      <= 1'b0;
      neg_r_reg      <= 1'b0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      dz_reg         <= 1'b0;
    end else begin
      dz_reg <= dz_start;
      if (accept) begin
        cnt_reg        <= '0;
        a_reg          <= a;
        b_reg          <= b;
        mul_signed_reg <= ~op[0];
        quo_reg        <= (~op[0] & a[WIDTH-1]) ? -a : a;
        dvs_reg        <= (~op[0] & b[WIDTH-1]) ? -b : b;
        rem_reg        <= '0;
        neg_q_reg      <= ~op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r_reg      <= ~op[0] & a[WIDTH-1];
      end else if (state_reg == S_MUL || state_reg == S_DIV) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (state_reg == S_DIV) begin
        quo_reg <= quo_step;
        rem_reg <= rem_step;
      end
      // A completing result takes priority over mthi/mtlo on the same edge.
      if (res_wr) begin
        hi_reg <= res_hi;
        lo_reg <= res_lo;
      end else begin
        if (hi_we) hi_reg <= wdata;
        if (lo_we) lo_reg <= wdata;
      end
    end
  end

  assign div_zero = (state_reg == S_DONE) && dz_reg;
  assign hi_out   = hi_reg;
  assign lo_out   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand-written multi-cycle sequences.
module tb_muldiv_unit;

  logic        clk, resetn, start, hi_we, lo_we, flush;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi_out, lo_out;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(32), .MUL_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
`ifdef MULDIV_FLUSH_EN
    .flush(flush),
`endif
    .busy(busy), .done(done), .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mt(input logic h, input logic l, input logic [31:0] d);
    hi_we = h; lo_we = l; wdata = d;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Issue one op, scramble the inputs after acceptance, then wait for done.
  task automatic run_op(input vec_t v, input int idx);
    int lat;
    int busy_cnt;
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    tick();
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    lat = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
      tick();
    end
    $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d",
             idx, v.op, v.a, v.b, hi_out, lo_out, div_zero, lat);
    chk($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("vec%0d hi", idx), hi_out, v.hi);
    chk($sformatf("vec%0d lo", idx), lo_out, v.lo);
    chk($sformatf("vec%0d div_zero", idx), {31'b0, div_zero}, {31'b0, v.dz});
    chk($sformatf("vec%0d busy_cycles", idx), 32'(busy_cnt), 32'(v.lat - 1));
  endtask

  initial begin
    int done_seen;
    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 2};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 2};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 33};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[5]  = '{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
    vecs[6]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
    vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 2};
    vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
    vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};
    vecs[10] = '{2'b01, 32'h12345678, 32'h00000009, 32'h00000000, 32'hA3D70A38, 1'b0, 2};
    vecs[11] = '{2'b10, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 33};

    resetn = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; flush = 1'b0;
    #2;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset div_zero", {31'b0, div_zero}, 32'd0);
    chk("reset hi", hi_out, 32'd0);
    chk("reset lo", lo_out, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Table: issued back to back, each start lands in the previous DONE cycle.
    for (int i = 0; i < 12; i++) run_op(vecs[i], i);
    tick();

    // mtlo in IDLE, then simultaneous mthi/mtlo.
    mt(1'b0, 1'b1, 32'h55);
    chk("mtlo lo", lo_out, 32'h55);
    $display("seq mtlo -> lo=%h", lo_out);
    mt(1'b1, 1'b1, 32'h77);
    chk("mthi+mtlo hi", hi_out, 32'h77);
    chk("mthi+mtlo lo", lo_out, 32'h77);
    $display("seq mthi+mtlo -> hi=%h lo=%h", hi_out, lo_out);

    // DIV -7/2 with an ignored MULT at cycle 5 and mthi at cycle 10.
    op = 2'b10; a = 32'hFFFFFFF9; b = 32'h2; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();       // cycle 5
    op = 2'b00; a = 32'h3; b = 32'h5; start = 1'b1;
    tick();                                   // cycle 6
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();       // cycle 10
    hi_we = 1'b1; wdata = 32'hAA;
    tick();                                   // cycle 11
    hi_we = 1'b0;
    chk("div mthi hi c11", hi_out, 32'hAA);
    for (int k = 0; k < 21; k++) tick();      // cycle 32
    chk("div mthi hi c32", hi_out, 32'hAA);
    chk("div busy c32", {31'b0, busy}, 32'd1);
    tick();                                   // cycle 33
    chk("div done c33", {31'b0, done}, 32'd1);
    chk("div hi c33", hi_out, 32'hFFFFFFFF);
    chk("div lo c33", lo_out, 32'hFFFFFFFD);
    $display("seq div+ignored start -> done=%0d hi=%h lo=%h", done, hi_out, lo_out);
    tick();                                   // cycle 34
    chk("div done pulse c34", {31'b0, done}, 32'd0);
    chk("div busy c34", {31'b0, busy}, 32'd0);

    // Result wins over mthi/mtlo on the completing edge.
    op = 2'b00; a = 32'h3; b = 32'h5; start = 1'b1;
    tick();
    start = 1'b0; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAA;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("result wins done", {31'b0, done}, 32'd1);
    chk("result wins hi", hi_out, 32'h0);
    chk("result wins lo", lo_out, 32'hF);
    $display("seq result-wins -> hi=%h lo=%h", hi_out, lo_out);
    tick();

    // Async reset during DIV cycle 12.
    mt(1'b1, 1'b1, 32'h1234);
    op = 2'b10; a = 32'h100; b = 32'h3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 11; k++) tick();      // cycle 12
    resetn = 1'b0;
    #1;
    chk("async rst busy", {31'b0, busy}, 32'd0);
    chk("async rst hi", hi_out, 32'd0);
    chk("async rst lo", lo_out, 32'd0);
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) done_seen++;
    end
    resetn = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) done_seen++;
    end
    chk("async rst no done", 32'(done_seen), 32'd0);
    $display("seq async reset -> busy=%0d hi=%h lo=%h done_seen=%0d", busy, hi_out, lo_out, done_seen);

`ifdef MULDIV_FLUSH_EN
    // Flush at DIV cycle 10.
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    op = 2'b11; a = 32'd100; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) tick();       // cycle 10
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'd0);
    done_seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (done) done_seen++;
      tick();
    end
    chk("flush no done", 32'(done_seen), 32'd0);
    chk("flush hi kept", hi_out, 32'h11);
    chk("flush lo kept", lo_out, 32'h22);
    $display("seq flush -> busy=%0d hi=%h lo=%h", busy, hi_out, lo_out);
    // Start with flush in IDLE is dropped; mtlo still lands.
    op = 2'b00; a = 32'h2; b = 32'h2; start = 1'b1; flush = 1'b1; lo_we = 1'b1; wdata = 32'h33;
    tick();
    start = 1'b0; flush = 1'b0; lo_we = 1'b0;
    chk("flush start busy", {31'b0, busy}, 32'd0);
    chk("flush mtlo lo", lo_out, 32'h33);
    tick();
    chk("flush start no done", {31'b0, done}, 32'd0);
    run_op(vecs[1], 101);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
